// File: rtl/gray_counter_if.sv
// Control and count bus of the binary/Gray up/down counter.
// The master drives the step/load controls; the slave presents both encodings of the count.
interface gray_counter_if #(
  parameter int DATA_WID = 4
);
  logic                en;
  logic                up_dn;
  logic                load;
  logic                load_is_gray;
  logic [DATA_WID-1:0] load_val;
  logic [DATA_WID-1:0] Bin;
  logic [DATA_WID-1:0] Gray;
  logic                wrap;

  modport master (
    output en, up_dn, load, load_is_gray, load_val,
    input  Bin, Gray, wrap
  );

  modport slave (
    input  en, up_dn, load, load_is_gray, load_val,
    output Bin, Gray, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs, synchronous binary/Gray load,
// and wrap or saturate behaviour at the limits. Gray is its own flop bank so CDC consumers see glitch-free edges.
module gray_counter #(
  parameter int DATA_WID = 4,
  parameter bit SAT_MODE = 1'b0
) (
  input logic          clk,
  input logic          rst,
  gray_counter_if.slave bus
);

  localparam logic [DATA_WID-1:0] MAX_CNT = '1;
  localparam logic [DATA_WID-1:0] ONE     = DATA_WID'(1);

  logic [DATA_WID-1:0] cnt;
  logic [DATA_WID-1:0] gray_q;
  logic                wrap_q;
  logic [DATA_WID-1:0] next_cnt;
  logic                next_wrap;

  function automatic logic [DATA_WID-1:0] gray_to_bin(input logic [DATA_WID-1:0] g);
    logic [DATA_WID-1:0] b;
    b[DATA_WID-1] = g[DATA_WID-1];
    for (int i = DATA_WID - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // At a limit the step either wraps around or holds; either way it is flagged.
  function automatic logic [DATA_WID:0] limit_step(input logic [DATA_WID-1:0] c, input logic up);
    logic [DATA_WID-1:0] n;
    logic                w;
    w = 1'b0;
    if (up) begin
      if (c == MAX_CNT) begin
        w = 1'b1;
        n = SAT_MODE ? MAX_CNT : '0;
      end else begin
        n = c + ONE;
      end
    end else begin
      if (c == '0) begin
        w = 1'b1;
        n = SAT_MODE ? '0 : MAX_CNT;
      end else begin
        n = c - ONE;
      end
    end
    return {w, n};
  endfunction

  always_comb begin
    next_cnt  = cnt;
    next_wrap = 1'b0;
    if (bus.load) begin
      next_cnt = bus.load_is_gray ? gray_to_bin(bus.load_val) : bus.load_val;
    end else if (bus.en) begin
      {next_wrap, next_cnt} = limit_step(cnt, bus.up_dn);
    end
  end

  // Stage p0: binary count, its Gray image and the boundary pulse all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= next_cnt;
      gray_q <= next_cnt ^ (next_cnt >> 1);
      wrap_q <= next_wrap;
    end
  end

  assign bus.Bin  = cnt;
  assign bus.Gray = gray_q;
  assign bus.wrap = wrap_q;

endmodule
